// File: rtl/shift_rows_stream.sv
// Rijndael ShiftRows / InvShiftRows stage for Nb = 4, 6 or 8 columns.
// Each beat carries its own mode, and the registered output sits behind a one-entry skid buffer.
module shift_rows_stream #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [32*NB-1:0]  data_in,
    input  logic [1:0]        mode_in,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [32*NB-1:0]  data_out,
    output logic [TAG_W-1:0]  tag_out,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int W = 32 * NB;

    generate
        if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
            $error("shift_rows_stream: NB must be 4, 6 or 8");
        end
    endgenerate

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t             state_q;
    state_t             state_n;
    logic [W-1:0]       xf;
    logic [W-1:0]       skid_data;
    logic [TAG_W-1:0]   skid_tag;
    logic               accept;
    logic               load_in;
    logic               load_skid;
    logic               take_skid;

    // Row 2 and row 3 shift by one extra position in 256-bit blocks
    function automatic int shift(input int r);
        if (NB == 8) return (r < 2) ? r : r + 1;
        return r;
    endfunction

    always_comb begin
        int src;
        xf  = data_in;
        src = 0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                unique case (mode_in)
                    2'b00:   src = (c + shift(r)) % NB;
                    2'b01:   src = (c + NB - shift(r)) % NB;
                    default: src = c;
                endcase
                xf[W-1-8*(4*c+r) -: 8] = data_in[W-1-8*(4*src+r) -: 8];
            end
        end
    end

    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q != EMPTY);

    always_comb begin
        state_n   = state_q;
        load_in   = 1'b0;
        load_skid = 1'b0;
        take_skid = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    load_in = 1'b1;
                    state_n = ONE;
                end
            end
            ONE: begin
                if (out_ready) begin
                    load_in = accept;
                    state_n = accept ? ONE : EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_n   = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    take_skid = 1'b1;
                    state_n   = ONE;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state_q  <= state_n;
            in_ready <= (state_n != FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out  <= '0;
            tag_out   <= '0;
            skid_data <= '0;
            skid_tag  <= '0;
        end else begin
            if (take_skid) begin
                data_out <= skid_data;
                tag_out  <= skid_tag;
            end else if (load_in) begin
                data_out <= xf;
                tag_out  <= tag_in;
            end
            if (load_skid) begin
                skid_data <= xf;
                skid_tag  <= tag_in;
            end
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// Bench for shift_rows_stream: directed vectors, backpressure, reset while full,
// and a long random valid/ready run checked against a byte-matrix model.
module tb_shift_rows_stream;
    localparam int TAG_W = 4;

    logic               clk = 0;
    logic               rst_n = 0;
    logic [127:0]       data_in = '0;
    logic [1:0]         mode_in = '0;
    logic [TAG_W-1:0]   tag_in = '0;
    logic               in_valid = 0;
    logic               in_ready;
    logic [127:0]       data_out;
    logic [TAG_W-1:0]   tag_out;
    logic               out_valid;
    logic               out_ready = 0;

    logic [255:0]       d8 = '0;
    logic [1:0]         m8 = '0;
    logic               v8 = 0;
    logic               r8;
    logic [255:0]       q8;
    logic [TAG_W-1:0]   t8;
    logic               ov8;

    int total = 0;
    int bad   = 0;
    int xfers = 0;

    logic [127+TAG_W:0] sb[$];
    logic               hold_pend = 0;
    logic [127+TAG_W:0] held;

    always #5 clk = ~clk;

    shift_rows_stream #(.NB(4), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .mode_in(mode_in),
        .tag_in(tag_in), .in_valid(in_valid), .in_ready(in_ready),
        .data_out(data_out), .tag_out(tag_out), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    shift_rows_stream #(.NB(8), .TAG_W(TAG_W)) dut8 (
        .clk(clk), .rst_n(rst_n), .data_in(d8), .mode_in(m8),
        .tag_in(4'h0), .in_valid(v8), .in_ready(r8),
        .data_out(q8), .tag_out(t8), .out_valid(ov8),
        .out_ready(1'b1)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // State as a 4 x nb byte matrix; rows rotate by the per-row offset
    function automatic logic [255:0] model(input logic [255:0] d, input logic [1:0] m, input int nb);
        logic [7:0]   st[4][8];
        logic [255:0] res;
        int           sh[4];
        int           src;
        res = '0;
        for (int r = 0; r < 4; r++) sh[r] = (nb == 8 && r >= 2) ? r + 1 : r;
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++)
                st[r][c] = d[32*nb-1-8*(4*c+r) -: 8];
        for (int c = 0; c < nb; c++)
            for (int r = 0; r < 4; r++) begin
                if (m == 2'b00)      src = (c + sh[r]) % nb;
                else if (m == 2'b01) src = (c - sh[r] + nb) % nb;
                else                 src = c;
                res[32*nb-1-8*(4*c+r) -: 8] = st[r][src];
            end
        return res;
    endfunction

    task automatic step(input logic iv, input logic [1:0] m, input logic [127:0] d,
                        input logic [TAG_W-1:0] t, input logic ordy, output logic acc);
        logic [255:0]       e;
        logic [127+TAG_W:0] exp;
        @(negedge clk);
        in_valid  = iv;
        mode_in   = m;
        data_in   = d;
        tag_in    = t;
        out_ready = ordy;
        if (hold_pend) begin
            chk("hold_valid", 256'(out_valid), 256'(1));
            chk("hold_data", 256'({data_out, tag_out}), 256'(held));
        end
        if (out_valid && out_ready) begin
            chk("beat_expected", 256'(sb.size() > 0), 256'(1));
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                chk("beat_data", 256'({data_out, tag_out}), 256'(exp));
                xfers++;
            end
        end
        hold_pend = out_valid && !out_ready;
        held      = {data_out, tag_out};
        acc       = iv && in_ready;
        if (acc) begin
            e = model(256'(d), m, 4);
            sb.push_back({e[127:0], t});
        end
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 20 && (sb.size() > 0 || out_valid); i++)
            step(0, 2'b00, '0, '0, 1, a);
        chk("drain_empty", 256'(sb.size()), 256'(0));
    endtask

    initial begin
        logic               a;
        logic [127:0]       t1_in;
        logic [127:0]       t1_out;
        logic [255:0]       asc;
        logic [255:0]       fwd8;
        logic [TAG_W-1:0]   rt;
        logic [1:0]         rm;
        logic [127:0]       rd;
        int                 acc_n;
        int                 x0;
        int                 irq;

        t1_in  = 128'hd42711aee0bf98f1b8b45de51e415230;
        t1_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

        #1;
        chk("rst_out_valid", 256'(out_valid), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(0));
        chk("rst_data_out", 256'(data_out), 256'(0));
        chk("rst_tag_out", 256'(tag_out), 256'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("ready_after_rst", 256'(in_ready), 256'(1));

        // T1 / T2 directed vectors
        step(1, 2'b00, t1_in, 4'h3, 1, a);
        chk("t1_accept", 256'(a), 256'(1));
        step(0, 2'b00, '0, '0, 1, a);
        chk("t1_valid", 256'(out_valid), 256'(1));
        chk("t1_fwd", 256'(data_out), 256'(t1_out));
        chk("t1_tag", 256'(tag_out), 256'(4'h3));
        step(1, 2'b01, t1_out, 4'h5, 1, a);
        step(1, 2'b10, t1_in, 4'h6, 1, a);
        chk("t2_inv", 256'(data_out), 256'(t1_in));
        step(1, 2'b11, t1_out, 4'h7, 1, a);
        chk("t2_byp", 256'(data_out), 256'(t1_in));
        step(0, 2'b00, '0, '0, 1, a);
        chk("t2_rsv", 256'(data_out), 256'(t1_out));
        drain();

        // T3 on the 8-column instance
        for (int k = 0; k < 32; k++) asc[255-8*k -: 8] = 8'(k);
        @(negedge clk);
        d8 = asc; m8 = 2'b00; v8 = 1;
        @(negedge clk);
        v8 = 0;
        fwd8 = q8;
        chk("t3_col0", 256'(q8[255:224]), 256'(32'h00050e13));
        chk("t3_fwd_model", q8, model(asc, 2'b00, 8));
        d8 = fwd8; m8 = 2'b01; v8 = 1;
        @(negedge clk);
        v8 = 0;
        chk("t3_inv", q8, asc);

        // T4 backpressure
        step(1, 2'b00, 128'h1, 4'h1, 0, a);
        chk("t4_acc1", 256'(a), 256'(1));
        step(1, 2'b01, 128'h2, 4'h2, 0, a);
        chk("t4_acc2", 256'(a), 256'(1));
        step(1, 2'b10, 128'h3, 4'h3, 0, a);
        chk("t4_ready_low", 256'(in_ready), 256'(0));
        step(1, 2'b10, 128'h3, 4'h3, 0, a);
        chk("t4_stalled", 256'(a), 256'(0));
        x0 = xfers;
        for (int i = 0; i < 10 && !a; i++) step(1, 2'b10, 128'h3, 4'h3, 1, a);
        chk("t4_acc3", 256'(a), 256'(1));
        drain();
        chk("t4_count", 256'(xfers - x0), 256'(3));

        // throughput with ready held high
        x0 = xfers;
        irq = 0;
        for (int i = 0; i < 50; i++) begin
            step(1, 2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom},
                 4'($urandom), 1, a);
            if (a) irq++;
        end
        chk("tp_accepts", 256'(irq), 256'(50));
        chk("tp_xfers", 256'(xfers - x0), 256'(49));
        drain();

        // T5 random handshake, mixed modes
        acc_n = 0;
        for (int i = 0; i < 40000 && acc_n < 10000; i++) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            rm = 2'($urandom_range(0, 3));
            rt = 4'($urandom);
            step(($urandom_range(0, 9) < 7), rm, rd, rt, ($urandom_range(0, 9) < 6), a);
            if (a) acc_n++;
        end
        chk("t5_beats", 256'(acc_n), 256'(10000));
        drain();

        // T6 reset while full
        step(1, 2'b00, t1_in, 4'h9, 0, a);
        step(1, 2'b01, t1_out, 4'ha, 0, a);
        step(0, 2'b00, '0, '0, 0, a);
        chk("t6_full_ready", 256'(in_ready), 256'(0));
        chk("t6_full_valid", 256'(out_valid), 256'(1));
        #2;
        rst_n = 0;
        out_ready = 1;
        #1;
        chk("t6_rst_valid", 256'(out_valid), 256'(0));
        chk("t6_rst_ready", 256'(in_ready), 256'(0));
        chk("t6_rst_data", 256'(data_out), 256'(0));
        sb.delete();
        hold_pend = 0;
        @(negedge clk);
        rst_n = 1;
        step(0, 2'b00, '0, '0, 1, a);
        chk("t6_ready_up", 256'(in_ready), 256'(1));
        chk("t6_no_stale", 256'(out_valid), 256'(0));
        step(0, 2'b00, '0, '0, 1, a);
        chk("t6_no_stale2", 256'(out_valid), 256'(0));
        step(1, 2'b00, t1_in, 4'h4, 1, a);
        step(0, 2'b00, '0, '0, 1, a);
        chk("t6_after", 256'(data_out), 256'(t1_out));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
